// File: rtl/iter_multiplier.sv
// Iterative RISC-V M-extension multiplier: retires BITS_PER_CYCLE_P multiplier bits per cycle,
// then presents the funct3-selected product in a one-cycle DONE state.
module iter_multiplier #(
  parameter int WIDTH_P          = 32,
  parameter int BITS_PER_CYCLE_P = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   flush_i,
  input  logic [2:0]             mul_funct3_i,
  input  logic [WIDTH_P-1:0]     multiplicand_i,
  input  logic [WIDTH_P-1:0]     multiplier_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic [2*WIDTH_P-1:0]   product_o,
  output logic [WIDTH_P-1:0]     result_o
);
  localparam int N  = WIDTH_P / BITS_PER_CYCLE_P;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH_P;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH_P-1:0] mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [1:0]         mode_q, mode_d;
  logic [PW-1:0]      product_q, product_d;
  logic [WIDTH_P-1:0] result_q, result_d;

  logic               a_signed, b_neg;
  logic [PW-1:0]      a_sx, pp;
  logic               unused_funct3;

  assign unused_funct3 = mul_funct3_i[2];

  // Signedness from funct3[1:0]: 00/01 both signed, 10 rs1 signed only, 11 both unsigned
  assign a_signed = (mul_funct3_i[1:0] != 2'b11);
  assign b_neg    = ~mul_funct3_i[1] & multiplier_i[WIDTH_P-1];
  assign a_sx     = {{WIDTH_P{a_signed & multiplicand_i[WIDTH_P-1]}}, multiplicand_i};

  always_comb begin
    pp = '0;
    for (int j = 0; j < BITS_PER_CYCLE_P; j++) begin
      if (mplier_q[j]) pp = pp + (mcand_q << j);
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    product_d = product_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_COMPUTE;
          count_d  = '0;
          mode_d   = mul_funct3_i[1:0];
          mcand_d  = a_sx;
          mplier_d = multiplier_i;
          // A signed rs2 sign bit weighs -2^W; pre-load that term so the loop stays unsigned
          acc_d    = b_neg ? (PW'(0) - (a_sx << WIDTH_P)) : '0;
        end
      end
      S_COMPUTE: begin
        if (count_q == CW'(N)) begin
          state_d   = S_DONE;
          product_d = acc_q;
          result_d  = (mode_q == 2'b00) ? acc_q[WIDTH_P-1:0] : acc_q[PW-1:WIDTH_P];
        end else begin
          acc_d    = acc_q + pp;
          mcand_d  = mcand_q << BITS_PER_CYCLE_P;
          mplier_d = mplier_q >> BITS_PER_CYCLE_P;
          count_d  = count_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d   = S_IDLE;
      product_d = product_q;
      result_d  = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      mode_q    <= '0;
      product_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      product_q <= product_d;
      result_q  <= result_d;
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign product_o = product_q;
  assign result_o  = result_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Randomised bench for iter_multiplier (32-bit, 2 bits/cycle) against an arithmetic product model.
module tb_iter_multiplier;
  localparam int W = 32;
  localparam int B = 2;
  localparam int N = W / B;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    f3 = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready, done;
  logic [2*W-1:0] prod;
  logic [W-1:0]  res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_multiplier #(.WIDTH_P(W), .BITS_PER_CYCLE_P(B)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .flush_i(flush),
    .mul_funct3_i(f3), .multiplicand_i(a), .multiplier_i(b),
    .ready_o(ready), .done_o(done), .product_o(prod), .result_o(res)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact product of the (W+1)-bit extended operands, truncated to 2W bits
  function automatic logic [63:0] ref_prod(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
    logic signed [32:0] ex, ey;
    logic signed [65:0] p;
    ex = {(m != 2'b11) & x[31], x};
    ey = {~m[1] & y[31], y};
    p  = ex * ey;
    return p[63:0];
  endfunction

  task automatic run_op(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y, input string tag);
    int lat;
    logic [63:0] e;
    logic [31:0] er;
    e  = ref_prod(m[1:0], x, y);
    er = (m[1:0] == 2'b00) ? e[31:0] : e[63:32];
    @(negedge clk);
    start = 1'b1; f3 = m; a = x; b = y;
    @(posedge clk); #1;
    chk({tag, "_busy"}, ready, 0);
    lat = 0;
    // Scramble inputs (including start) while busy; none of it may matter
    while (!done && lat < 40) begin
      start = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; f3 = 3'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, N + 1);
    chk({tag, "_prod"}, prod, e);
    chk({tag, "_res"}, res, er);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_rdy"}, ready, 1);
  endtask

  initial begin
    logic [63:0] p_prev;
    logic [31:0] r_prev;
    int saw;

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_prod", prod, 0);
    chk("rst_res", res, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul_ff");
    chk("mul_ff_const", prod, 64'h0000000000000001);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_ff");
    chk("mulhu_ff_const", prod, 64'hFFFFFFFE00000001);
    chk("mulhu_ff_rconst", res, 64'hFFFFFFFE);
    run_op(3'b001, 32'h80000000, 32'h80000000, "mulh_min");
    chk("mulh_min_const", prod, 64'h4000000000000000);
    run_op(3'b010, 32'hFFFFFFFE, 32'h80000000, "mulhsu");
    chk("mulhsu_const", prod, 64'hFFFFFFFF00000000);
    chk("mulhsu_rconst", res, 64'hFFFFFFFF);
    run_op(3'b100, 32'h00001234, 32'hFFFFFFFF, "mul_bit2");
    run_op(3'b001, 32'h00000000, 32'hDEADBEEF, "zero_a");
    run_op(3'b011, 32'h7FFFFFFF, 32'h00000000, "zero_b");

    for (int i = 0; i < 60; i++) begin
      logic [31:0] x, y;
      x = $urandom; y = $urandom;
      if (i % 7 == 0) x = 32'h80000000;
      if (i % 5 == 0) y = 32'hFFFFFFFF;
      run_op(3'($urandom), x, y, "rand");
    end

    // Start together with flush in IDLE must not be accepted
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("idle_flush_start", ready, 1);
    @(negedge clk); start = 1'b0; flush = 1'b0;

    for (int v = 0; v < 2; v++) begin
      run_op(3'b001, $urandom, $urandom, "pre_flush");
      p_prev = prod; r_prev = res;
      @(negedge clk); start = 1'b1; f3 = 3'b000; a = $urandom; b = $urandom;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); flush = 1'b1; start = 1'(v);
      @(posedge clk); #1;
      chk("flush_idle", ready, 1);
      chk("flush_done", done, 0);
      chk("flush_prod", prod, p_prev);
      chk("flush_res", res, r_prev);
      @(negedge clk); flush = 1'b0; start = 1'b0;
      saw = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (done || !ready) saw++;
      end
      chk("flush_quiet", saw, 0);
      chk("flush_hold", prod, p_prev);
      run_op(3'($urandom), $urandom, $urandom, "post_flush");
    end

    // Asynchronous reset in the middle of COMPUTE
    run_op(3'b011, 32'hFFFFFFFF, 32'h12345678, "pre_rst");
    @(negedge clk); start = 1'b1; f3 = 3'b000; a = 32'h55; b = 32'h77;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_done", done, 0);
    chk("arst_prod", prod, 0);
    chk("arst_res", res, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(3'b000, 32'hFFFFFFF9, 32'h00000013, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
